// File: rtl/bit32_seq_leftshift.sv
// Sequential 32-bit logical left shifter.
// One bit of shift per clock in SHIFT; a shift amount of 32 or more
// short-circuits to a zero result with no shift cycles.
module bit32_seq_leftshift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] work;
  logic [4:0]  cnt;
  logic        overflow;
  logic        accept;

  // Any set bit above bit 4 shifts every operand bit out of the word.
  assign overflow = |b[31:5];
  // Requests are only honoured in IDLE; nothing is queued otherwise.
  assign accept   = (state == IDLE) && start;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (overflow || (b[4:0] == 5'd0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 5'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working register and remaining-shift counter.
  // The operands are copied at acceptance, so later changes on a/b are
  // invisible to the operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= 32'h0;
      cnt  <= 5'd0;
    end else if (accept) begin
      work <= overflow ? 32'h0 : a;
      cnt  <= overflow ? 5'd0  : b[4:0];
    end else if (state == SHIFT) begin
      work <= {work[30:0], 1'b0};
      cnt  <= cnt - 5'd1;
    end
  end

  // The result port is the working register itself; it holds through IDLE.
  assign s = work;

endmodule

// File: tb/tb_bit32_seq_leftshift.sv
// Self-checking bench for bit32_seq_leftshift.
// Expected results are pushed to a scoreboard when a request is driven and
// popped when the DUT raises done.
module tb_bit32_seq_leftshift;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = 32'h0;
  logic [31:0] b     = 32'h0;
  logic [31:0] s;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int accept_at = 0;

  typedef struct {
    logic [31:0] s;
    int          n;
  } exp_t;

  exp_t sb[$];

  bit32_seq_leftshift dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .s     (s),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: logical shift, zero once the amount reaches the word width.
  function automatic exp_t model(input logic [31:0] op_a, input logic [31:0] op_b);
    exp_t e;
    if (op_b >= 32'd32) begin
      e.s = 32'h0;
      e.n = 0;
    end else begin
      e.s = op_a << op_b;
      e.n = int'(op_b);
    end
    return e;
  endfunction

  // Issue one request at a negedge and follow it to done.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input int pulse_cyc, input bit scramble, input string name);
    exp_t e;
    int   n;
    int   done_cyc;
    bit   busy_err;
    @(negedge clk);
    a         = op_a;
    b         = op_b;
    start     = 1'b1;
    accept_at = edge_cnt;
    sb.push_back(model(op_a, op_b));
    n         = sb[0].n;
    done_cyc  = -1;
    busy_err  = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      if (cyc == pulse_cyc) begin
        a     = 32'd5;
        b     = 32'd1;
        start = 1'b1;
      end
      if (busy !== (cyc <= n)) busy_err = 1'b1;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (done_cyc != e.n + 1) begin
      n_bad++;
      $display("FAIL %s latency: got cycle %0d expected cycle %0d", name, done_cyc, e.n + 1);
    end
    n_cmp++;
    if (s !== e.s) begin
      n_bad++;
      $display("FAIL %s result: got %h expected %h", name, s, e.s);
    end
    n_cmp++;
    if (busy_err) begin
      n_bad++;
      $display("FAIL %s busy profile: got irregular busy expected high in cycles 1..%0d only", name, e.n);
    end
  endtask

  // Quiet IDLE: no done, no busy, s held.
  task automatic hold_check(input logic [31:0] exp_s, input int k, input string name);
    bit bad = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || s !== exp_s) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s idle hold: got s=%h busy=%b done=%b expected s=%h busy=0 done=0",
               name, s, busy, done, exp_s);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (s !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got s=%h busy=%b done=%b expected s=0 busy=0 done=0", s, busy, done);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (s !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held: got s=%h busy=%b done=%b expected s=0 busy=0 done=0", s, busy, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(32'h00000001, 32'd4, 0, 1'b0, "basic");
    hold_check(32'h00000010, 3, "basic");
  endtask

  task automatic test_zero();
    run_op(32'hDEADBEEF, 32'd0, 0, 1'b0, "zero");
    hold_check(32'hDEADBEEF, 2, "zero");
  endtask

  task automatic test_overflow();
    run_op(32'h12345678, 32'd32, 0, 1'b0, "ovf32");
    run_op(32'hFFFFFFFF, 32'h00000120, 0, 1'b0, "ovf120");
    run_op(32'hA5A5A5A5, 32'h80000003, 0, 1'b0, "ovf_msb");
  endtask

  task automatic test_max_and_ignore();
    run_op(32'hFFFFFFFF, 32'd31, 10, 1'b0, "max");
    hold_check(32'h80000000, 4, "max");
  endtask

  task automatic test_ignore_in_done();
    run_op(32'h000000A5, 32'd3, 0, 1'b0, "in_done");
    start = 1'b1;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    hold_check(32'h00000528, 3, "in_done");
  endtask

  task automatic test_scramble();
    for (int i = 0; i < 5; i++) begin
      run_op($urandom, 32'($urandom_range(0, 40)), 0, 1'b1, "scramble");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops_a [4] = '{32'h00000003, 32'h0F0F0F0F, 32'h00000001, 32'h12345678};
    logic [31:0] ops_b [4] = '{32'd5, 32'd0, 32'd31, 32'd40};
    int prev_at;
    int prev_n;
    for (int i = 0; i < 4; i++) begin
      run_op(ops_a[i], ops_b[i], 0, 1'b0, "b2b");
      if (i > 0) begin
        n_cmp++;
        if (accept_at - prev_at != prev_n + 2) begin
          n_bad++;
          $display("FAIL b2b interval: got %0d expected %0d", accept_at - prev_at, prev_n + 2);
        end
      end
      prev_at = accept_at;
      prev_n  = (ops_b[i] >= 32'd32) ? 0 : int'(ops_b[i]);
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    @(negedge clk);
    a     = 32'h0000000F;
    b     = 32'd20;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort pre: got busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort immediate: got s=%h busy=%b done=%b expected s=0 busy=0 done=0", s, busy, done);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0 || s !== 32'h0) begin
      n_bad++;
      $display("FAIL abort after release: got %0d active cycles s=%h expected 0 active cycles s=0",
               done_seen, s);
    end
    run_op(32'd3, 32'd2, 0, 1'b0, "recover");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_max_and_ignore();
    test_ignore_in_done();
    test_scramble();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
